// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: FSM states, bus widths and
// the {pc, word} entry carried through the prefetch FIFO.
package fetch_pkg;

    localparam int unsigned FETCH_ADDR_W = 16;
    localparam int unsigned FETCH_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_DATA_W-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of fetch entries. Flush beats push and pop. When empty the
// head port keeps showing the last entry that was presented.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     hold_q;
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[PTR_W-1] != rd_q[PTR_W-1]) &&
                     (wr_q[IDX_W-1:0] == rd_q[IDX_W-1:0]);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = empty ? hold_q : mem_q[rd_q[IDX_W-1:0]];

    // Pointer next-state; flush empties the queue outright.
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (flush) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (push_ok) wr_d = wr_q + PTR_W'(1);
            if (pop_ok)  rd_d = rd_q + PTR_W'(1);
        end
    end

    // Pointer and hold registers; hold tracks the presented head.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_q   <= '0;
            rd_q   <= '0;
            hold_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            if (!empty) hold_q <= mem_q[rd_q[IDX_W-1:0]];
        end
    end

    // Entry storage; contents are only observed through valid pointers.
    always_ff @(posedge CLK) begin
        if (!flush && push_ok) mem_q[wr_q[IDX_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC, ROM addressing, prefetch FIFO and decoder
// handshake with redirect/flush. Optional perf counters under FETCH_PERF_EN.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = FETCH_ADDR_W,
    parameter int unsigned       DATA_W   = FETCH_DATA_W,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              enable,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [1:0]        fetch_state
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetch_count,
    output logic [31:0]       perf_stall_count
`endif
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop_c;
    logic              push_c;
    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;

    assign pop_c  = instr_valid && instr_ready;
    assign push_c = (state_q == RUN) && enable && !redirect_valid &&
                    (!fifo_full || pop_c);

    assign push_entry.pc   = FETCH_ADDR_W'(pc_q);
    assign push_entry.data = FETCH_DATA_W'(rom_data);

    // FSM next-state and PC update; redirect overrides everything.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            IDLE:    if (enable)  state_d = RUN;
            RUN:     if (!enable) state_d = IDLE;
            FLUSH:   state_d = enable ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
        if (push_c) pc_d = pc_q + ADDR_W'(1);
        if (redirect_valid) begin
            state_d = FLUSH;
            pc_d    = redirect_pc;
        end
    end

    // State and PC registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (push_c),
        .push_data (push_entry),
        .pop       (pop_c),
        .flush     (redirect_valid),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head_entry)
    );

    assign rom_address = pc_q;
    assign instr_valid = !fifo_empty;
    assign instr_data  = DATA_W'(head_entry.data);
    assign instr_pc    = ADDR_W'(head_entry.pc);
    assign fetch_state = state_q;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_stall_q;
    logic        stall_c;

    assign stall_c = (state_q == RUN) && enable && !redirect_valid &&
                     fifo_full && !pop_c;

    // Push and full-stall counters; free-running, survive redirects.
    always_ff @(posedge CLK) begin
        if (RST) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (push_c)  perf_fetch_q <= perf_fetch_q + 32'd1;
            if (stall_c) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_fetch_count = perf_fetch_q;
    assign perf_stall_count = perf_stall_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: cycle table for start-up/drain, scoreboard of
// expected delivered PCs for fill, redirect, wrap and reset sequences.
module tb_instruction_fetch;

    logic        CLK;
    logic        RST;
    logic        enable;
    logic [15:0] rom_address;
    logic [31:0] rom_data;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [15:0] instr_pc;
    logic [1:0]  fetch_state;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_count;
    logic [31:0] perf_stall_count;
`endif

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_q[$];

    instruction_fetch dut (
        .CLK            (CLK),
        .RST            (RST),
        .enable         (enable),
        .rom_address    (rom_address),
        .rom_data       (rom_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .fetch_state    (fetch_state)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_count (perf_fetch_count),
        .perf_stall_count (perf_stall_count)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Program ROM model: a few fixed words, zero high region, pattern elsewhere.
    function automatic logic [31:0] rom_word(input logic [15:0] a);
        case (a)
            16'h0000: return 32'h00010006;
            16'h0001: return 32'h00002006;
            16'h0002: return 32'h00004006;
            16'h0008: return 32'h00030188;
            default:  return (a >= 16'hFF00) ? 32'h0 : {a ^ 16'h5A5A, a};
        endcase
    endfunction

    assign rom_data = rom_word(rom_address);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted head must be the next expected PC and its word.
    always @(negedge CLK) begin
        if (!RST && instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_extra actual_pc=%0h expected=none", instr_pc);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                chk("sb_pc", 64'(instr_pc), 64'(e));
                chk("sb_data", 64'(instr_data), 64'(rom_word(e)));
            end
        end
    end

    task automatic rst_dut();
        RST            = 1'b1;
        enable         = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    typedef struct {
        logic        en;
        logic        rdy;
        logic        valid;
        logic [15:0] pc;
        logic [31:0] data;
        logic [1:0]  st;
        logic [15:0] addr;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Start-up and drain expectations, one row per cycle.
        tbl[0] = '{1'b1, 1'b1, 1'b0, 16'd0, 32'h0,        2'd0, 16'd0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 16'd0, 32'h0,        2'd1, 16'd0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 16'd0, 32'h00010006, 2'd1, 16'd1};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 16'd1, 32'h00002006, 2'd1, 16'd2};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 16'd2, 32'h00004006, 2'd1, 16'd3};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 16'd3, 32'h5A590003, 2'd1, 16'd4};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 16'd3, 32'h5A590003, 2'd0, 16'd4};

        rst_dut();
        chk("rst_valid", 64'(instr_valid), 64'd0);
        chk("rst_data",  64'(instr_data),  64'd0);
        chk("rst_pc",    64'(instr_pc),    64'd0);
        chk("rst_state", 64'(fetch_state), 64'd0);
        chk("rst_addr",  64'(rom_address), 64'd0);

        // Table: consecutive delivery then drain with enable low.
        for (int i = 0; i < 4; i++) exp_q.push_back(16'(i));
        for (int i = 0; i < 7; i++) begin
            enable      = tbl[i].en;
            instr_ready = tbl[i].rdy;
            chk($sformatf("tbl%0d_valid", i), 64'(instr_valid), 64'(tbl[i].valid));
            chk($sformatf("tbl%0d_pc", i),    64'(instr_pc),    64'(tbl[i].pc));
            chk($sformatf("tbl%0d_data", i),  64'(instr_data),  64'(tbl[i].data));
            chk($sformatf("tbl%0d_state", i), 64'(fetch_state), 64'(tbl[i].st));
            chk($sformatf("tbl%0d_addr", i),  64'(rom_address), 64'(tbl[i].addr));
            @(posedge CLK);
            #1;
        end
        chk("tbl_drain", 64'(exp_q.size()), 64'd0);

        // Fill with decoder stalled, then stream through a full FIFO.
        rst_dut();
        for (int i = 0; i < 8; i++) exp_q.push_back(16'(i));
        enable = 1'b1;
        repeat (8) @(posedge CLK);
        #1;
        chk("full_addr",  64'(rom_address), 64'd4);
        chk("full_valid", 64'(instr_valid), 64'd1);
        chk("full_head",  64'(instr_pc),    64'd0);
        chk("full_state", 64'(fetch_state), 64'd1);
        instr_ready = 1'b1;
        repeat (8) @(posedge CLK);
        #1;
        instr_ready = 1'b0;
        chk("stream_drain", 64'(exp_q.size()), 64'd0);
        chk("stream_head",  64'(instr_pc),     64'd8);
        chk("stream_addr",  64'(rom_address),  64'd12);

        // Redirect while three entries are queued.
        rst_dut();
        enable = 1'b1;
        repeat (4) @(posedge CLK);
        #1;
        chk("pre_redir_valid", 64'(instr_valid), 64'd1);
        chk("pre_redir_addr",  64'(rom_address), 64'd3);
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0008;
        @(posedge CLK);
        #1;
        redirect_valid = 1'b0;
        chk("flush_valid", 64'(instr_valid), 64'd0);
        chk("flush_state", 64'(fetch_state), 64'd2);
        chk("flush_addr",  64'(rom_address), 64'h8);
        exp_q.push_back(16'h0008);
        exp_q.push_back(16'h0009);
        exp_q.push_back(16'h000A);
        @(posedge CLK);
        #1;
        chk("post_flush_state", 64'(fetch_state), 64'd1);
        chk("post_flush_valid", 64'(instr_valid), 64'd0);
        instr_ready = 1'b1;
        @(posedge CLK);
        #1;
        chk("redir_first_valid", 64'(instr_valid), 64'd1);
        chk("redir_first_pc",    64'(instr_pc),    64'h8);
        chk("redir_first_data",  64'(instr_data),  64'h00030188);
        repeat (3) @(posedge CLK);
        #1;
        instr_ready = 1'b0;
        chk("redir_drain", 64'(exp_q.size()), 64'd0);

        // Redirect in the same cycle as a pop.
        rst_dut();
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'h0002);
        exp_q.push_back(16'h0020);
        exp_q.push_back(16'h0021);
        exp_q.push_back(16'h0022);
        enable      = 1'b1;
        instr_ready = 1'b1;
        repeat (4) @(posedge CLK);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0020;
        @(posedge CLK);
        #1;
        redirect_valid = 1'b0;
        chk("pop_redir_valid", 64'(instr_valid), 64'd0);
        chk("pop_redir_state", 64'(fetch_state), 64'd2);
        repeat (5) @(posedge CLK);
        #1;
        instr_ready = 1'b0;
        chk("pop_redir_drain", 64'(exp_q.size()), 64'd0);

        // Back-to-back redirects, second target wraps past 0xFFFF.
        exp_q.push_back(16'hFFFE);
        exp_q.push_back(16'hFFFF);
        exp_q.push_back(16'h0000);
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0040;
        @(posedge CLK);
        #1;
        redirect_pc = 16'hFFFE;
        chk("b2b_state1", 64'(fetch_state), 64'd2);
        @(posedge CLK);
        #1;
        redirect_valid = 1'b0;
        chk("b2b_state2", 64'(fetch_state), 64'd2);
        chk("b2b_addr",   64'(rom_address), 64'hFFFE);
        instr_ready = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
        instr_ready = 1'b0;
        chk("wrap_drain", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of a full stream, with redirect also raised.
        repeat (6) @(posedge CLK);
        #1;
        chk("pre_rst_valid", 64'(instr_valid), 64'd1);
        RST            = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0055;
        @(posedge CLK);
        #1;
        RST            = 1'b0;
        redirect_valid = 1'b0;
        chk("mid_rst_valid", 64'(instr_valid), 64'd0);
        chk("mid_rst_addr",  64'(rom_address), 64'd0);
        chk("mid_rst_state", 64'(fetch_state), 64'd0);
        chk("mid_rst_pc",    64'(instr_pc),    64'd0);
        chk("mid_rst_data",  64'(instr_data),  64'd0);
`ifdef FETCH_PERF_EN
        chk("mid_rst_perf_fetch", 64'(perf_fetch_count), 64'd0);
        chk("mid_rst_perf_stall", 64'(perf_stall_count), 64'd0);
`endif
        chk("final_queue", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage that drives the program ROM address and consumes its 32-bit instruction word.
- Holds the program counter, captures {pc, word} pairs into a small prefetch FIFO and presents them to the decoder over a valid/ready handshake.
- Supports branch/jump redirect with FIFO flush and a run/idle enable.
- Sits between the program ROM (combinational read, data valid in the same cycle the address is presented) and the decode stage.

Parameters:
- ADDR_W, 16, ROM word-address and PC width
- DATA_W, 32, instruction word width
- DEPTH, 4, prefetch FIFO entries (power of two, at least 2)
- RESET_PC, 16'h0000, PC value loaded on reset

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- enable  in  1  1 = fetch, 0 = stop issuing new fetches
- rom_address  out  ADDR_W  address to program ROM, equal to the PC register
- rom_data  in  DATA_W  ROM word for rom_address, same cycle
- redirect_valid  in  1  single-cycle branch/jump request
- redirect_pc  in  ADDR_W  redirect target
- instr_valid  out  1  FIFO head valid
- instr_ready  in  1  decoder accepts head
- instr_data  out  DATA_W  head instruction word
- instr_pc  out  ADDR_W  head instruction address
- fetch_state  out  2  current FSM state (debug)

Behaviour:
- One clock (CLK); reset is synchronous and active-high (RST). All state updates on the rising edge of CLK.
- Reset values:
  - PC = RESET_PC; FIFO empty; state = IDLE.
  - instr_valid = 0; instr_data = 0; instr_pc = 0; fetch_state = 2'd0.
  - rom_address = RESET_PC.
- FSM encodings: IDLE = 0, RUN = 1, FLUSH = 2.
  - IDLE -> RUN when enable = 1.
  - RUN -> IDLE when enable = 0.
  - Any state -> FLUSH on redirect_valid.
  - FLUSH -> RUN next cycle if enable, else IDLE.
- Push, RUN only:
  - Condition: no redirect_valid, and either FIFO not full, or full with a pop in the same cycle.
  - Action: write {PC, rom_data}; PC <= PC + 1.
  - Throughput: one word per cycle.
- PC wrap-around: PC = 16'hFFFF increments to 16'h0000, no flag.
- Pop: occurs when instr_valid && instr_ready; head advances.
- Output timing:
  - instr_valid, instr_data and instr_pc come from registered FIFO storage.
  - A word pushed in cycle N is visible at the head in cycle N+1 (latency 1) when the FIFO was empty.
- Redirect has priority over everything:
  - Same edge: FIFO emptied, PC <= redirect_pc, no push.
  - A pop in the same cycle is still counted as accepted by the decoder; no replay.
  - instr_valid = 0 during the FLUSH cycle.
  - First push is from redirect_pc in the following RUN cycle.
  - Back-to-back redirects: the latest target wins; the FSM stays in FLUSH.
- Full/empty:
  - Full and no pop: the PC holds and the same address is re-presented.
  - Empty: instr_valid = 0; instr_data and instr_pc hold their last value.
- enable low: no pushes; the FIFO continues to drain; PC holds.
- RST mid-operation overrides redirect and enable; everything returns to reset values.
- FIFO occupancy: pointers of width log2(DEPTH)+1; full = MSBs differ and LSBs equal.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined, adds two outputs:
  - perf_fetch_count, out, 32 bits: increments on each push.
  - perf_stall_count, out, 32 bits: increments on each RUN cycle that is blocked by a full FIFO.
  - Both reset to 0, wrap at 2^32, and are not cleared by redirect.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package fetch_pkg holds:
  - fetch_state_t enum (IDLE/RUN/FLUSH)
  - FETCH_ADDR_W and FETCH_DATA_W constants
  - fetch_entry_t struct {pc, data}
- Sub-module fetch_fifo:
  - synchronous FIFO of fetch_entry_t, DEPTH entries
  - ports: push, pop, flush, full, empty, head
  - flush has priority over push and pop.

Test Plan:
- Reset, enable=1, instr_ready=1, ROM words 0x00010006, 0x00002006, 0x00004006 at addresses 0..2 -> instr_pc 0,1,2 on consecutive cycles starting 2 cycles after enable; instr_data matches each word.
- instr_ready=0 with DEPTH=4 -> exactly 4 pushes, then PC holds at 4 and rom_address = 4; raise instr_ready -> entries 0..3 drain in order, then PC 4 continues with no gap or duplicate.
- Redirect to 0x0008 while FIFO holds 3 entries -> next cycle instr_valid = 0 and fetch_state = 2; the cycle after, push from PC 0x0008; first delivered instr_pc = 0x0008 with data 0x00030188.
- Redirect coincident with pop -> popped entry accepted once; no stale entry delivered after the flush.
- redirect_pc = 0xFFFE -> delivered pcs 0xFFFE, 0xFFFF, 0x0000; words at 0xFFFE/0xFFFF read as 0 from the unpopulated ROM region.
- RST asserted mid-stream with FIFO full -> next cycle instr_valid = 0, PC = RESET_PC, state IDLE; with FETCH_PERF_EN, both counters read 0.
